// File: rtl/draw_cat_sprite.sv
// draw_cat_sprite: read side of the 64x64 cat image ROM in the VGA pixel pipeline.
// Drives the ROM address from the incoming timing and the latched sprite position.
// Overlays ROM pixels on the background, using a colour key for transparency.
// All timing is re-aligned so that outputs lag inputs by exactly three clocks.
module draw_cat_sprite #(
    parameter int          IMG_W       = 64,
    parameter int          IMG_H       = 64,
    parameter int          ADDR_X_BITS = 6,
    parameter int          ADDR_Y_BITS = 6,
    parameter bit          TRANSP_EN   = 1'b1,
    parameter logic [11:0] TRANSP_RGB  = 12'h0F0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [10:0]                        hcount_in,
    input  logic [10:0]                        vcount_in,
    input  logic                               hsync_in,
    input  logic                               hblnk_in,
    input  logic                               vsync_in,
    input  logic                               vblnk_in,
    input  logic [11:0]                        rgb_in,
    input  logic [11:0]                        xpos,
    input  logic [11:0]                        ypos,
    input  logic [11:0]                        rgb_pixel,
    output logic [ADDR_Y_BITS+ADDR_X_BITS-1:0] pixel_addr,
    output logic [10:0]                        hcount_out,
    output logic [10:0]                        vcount_out,
    output logic                               hsync_out,
    output logic                               hblnk_out,
    output logic                               vsync_out,
    output logic                               vblnk_out,
    output logic [11:0]                        rgb_out
);

    // Sprite position, only refreshed at the start of vertical blanking
    logic [11:0] xpos_q;
    logic [11:0] ypos_q;
    logic        vblnk_prev_q;

    // Stage 1 pipeline registers
    logic [10:0] hcount_s1_q;
    logic [10:0] vcount_s1_q;
    logic        hsync_s1_q;
    logic        hblnk_s1_q;
    logic        vsync_s1_q;
    logic        vblnk_s1_q;
    logic [11:0] rgb_s1_q;
    logic        inside_s1_q;

    // Stage 2 pipeline registers (ROM read happens alongside this stage)
    logic [10:0] hcount_s2_q;
    logic [10:0] vcount_s2_q;
    logic        hsync_s2_q;
    logic        hblnk_s2_q;
    logic        vsync_s2_q;
    logic        vblnk_s2_q;
    logic [11:0] rgb_s2_q;
    logic        inside_s2_q;

    // Next-state values computed combinationally
    logic                               latch_d;
    logic [12:0]                        hcount_ext;
    logic [12:0]                        vcount_ext;
    logic [12:0]                        xstart_ext;
    logic [12:0]                        ystart_ext;
    logic [12:0]                        xend_ext;
    logic [12:0]                        yend_ext;
    logic                               inside_d;
    logic [ADDR_X_BITS-1:0]             col_d;
    logic [ADDR_Y_BITS-1:0]             row_d;
    logic [ADDR_Y_BITS+ADDR_X_BITS-1:0] addr_d;
    logic                               key_hit;
    logic                               blank_s2;
    logic [11:0]                        rgb_out_d;

    // Sprite window test in 13 bits so that a sprite near the right/bottom
    // edge is clipped rather than wrapping around to column/row zero
    always_comb begin
        latch_d    = vblnk_in & ~vblnk_prev_q;
        hcount_ext = {2'b00, hcount_in};
        vcount_ext = {2'b00, vcount_in};
        xstart_ext = {1'b0, xpos_q};
        ystart_ext = {1'b0, ypos_q};
        xend_ext   = xstart_ext + 13'(IMG_W);
        yend_ext   = ystart_ext + 13'(IMG_H);
        inside_d   = (hcount_ext >= xstart_ext) && (hcount_ext < xend_ext) &&
                     (vcount_ext >= ystart_ext) && (vcount_ext < yend_ext) &&
                     !hblnk_in && !vblnk_in;
        // Low bits of the difference only depend on the low bits of the operands
        col_d      = hcount_in[ADDR_X_BITS-1:0] - xpos_q[ADDR_X_BITS-1:0];
        row_d      = vcount_in[ADDR_Y_BITS-1:0] - ypos_q[ADDR_Y_BITS-1:0];
        addr_d     = inside_d ? {row_d, col_d} : '0;
    end

    // Final compositing: blanking wins, then opaque sprite pixels, else background
    always_comb begin
        key_hit   = TRANSP_EN && (rgb_pixel == TRANSP_RGB);
        blank_s2  = hblnk_s2_q | vblnk_s2_q;
        rgb_out_d = rgb_s2_q;
        if (blank_s2) begin
            rgb_out_d = 12'h000;
        end else if (inside_s2_q && !key_hit) begin
            rgb_out_d = rgb_pixel;
        end
    end

    // Latch the sprite position on the rising edge of vblank
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_q       <= '0;
            ypos_q       <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_in;
            if (latch_d) begin
                xpos_q <= xpos;
                ypos_q <= ypos;
            end
        end
    end

    // Stage 1: capture timing and background, issue the ROM address
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_s1_q <= '0;
            vcount_s1_q <= '0;
            hsync_s1_q  <= 1'b0;
            hblnk_s1_q  <= 1'b0;
            vsync_s1_q  <= 1'b0;
            vblnk_s1_q  <= 1'b0;
            rgb_s1_q    <= '0;
            inside_s1_q <= 1'b0;
            pixel_addr  <= '0;
        end else begin
            hcount_s1_q <= hcount_in;
            vcount_s1_q <= vcount_in;
            hsync_s1_q  <= hsync_in;
            hblnk_s1_q  <= hblnk_in;
            vsync_s1_q  <= vsync_in;
            vblnk_s1_q  <= vblnk_in;
            rgb_s1_q    <= rgb_in;
            inside_s1_q <= inside_d;
            pixel_addr  <= addr_d;
        end
    end

    // Stage 2: pure delay while the ROM registers its data
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_s2_q <= '0;
            vcount_s2_q <= '0;
            hsync_s2_q  <= 1'b0;
            hblnk_s2_q  <= 1'b0;
            vsync_s2_q  <= 1'b0;
            vblnk_s2_q  <= 1'b0;
            rgb_s2_q    <= '0;
            inside_s2_q <= 1'b0;
        end else begin
            hcount_s2_q <= hcount_s1_q;
            vcount_s2_q <= vcount_s1_q;
            hsync_s2_q  <= hsync_s1_q;
            hblnk_s2_q  <= hblnk_s1_q;
            vsync_s2_q  <= vsync_s1_q;
            vblnk_s2_q  <= vblnk_s1_q;
            rgb_s2_q    <= rgb_s1_q;
            inside_s2_q <= inside_s1_q;
        end
    end

    // Stage 3: register the composited pixel together with its timing
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s2_q;
            vcount_out <= vcount_s2_q;
            hsync_out  <= hsync_s2_q;
            hblnk_out  <= hblnk_s2_q;
            vsync_out  <= vsync_s2_q;
            vblnk_out  <= vblnk_s2_q;
            rgb_out    <= rgb_out_d;
        end
    end

endmodule

// File: tb/tb_draw_cat_sprite.sv
// tb_draw_cat_sprite: directed vectors for the cat sprite overlay.
// Stimulus pushes expected address/pixel results into queues; a monitor
// pops and compares them when the matching DUT output appears.
module tb_draw_cat_sprite;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic [11:0] rgb_pixel = '0;
    logic [11:0] pixel_addr;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;

    typedef struct packed {
        logic [11:0] addr;
        logic        rstChk;
    } addrExp_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic [3:0]  syncs;
        logic [11:0] rgb;
    } outExp_t;

    addrExp_t addrQ[$];
    outExp_t  outQ[$];

    logic tagIn = 1'b0;
    logic tag1  = 1'b0;
    logic tag2  = 1'b0;
    logic tag3  = 1'b0;

    int checks = 0;
    int errors = 0;

    draw_cat_sprite dut (
        .clk(clk),
        .rst(rst),
        .hcount_in(hcount_in),
        .vcount_in(vcount_in),
        .hsync_in(hsync_in),
        .hblnk_in(hblnk_in),
        .vsync_in(vsync_in),
        .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .xpos(xpos),
        .ypos(ypos),
        .rgb_pixel(rgb_pixel),
        .pixel_addr(pixel_addr),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out(hsync_out),
        .hblnk_out(hblnk_out),
        .vsync_out(vsync_out),
        .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    // Pixel clock
    always #5 clk = ~clk;

    // ROM contents: address plus a constant, with one colour-key entry at 0x041
    function automatic logic [11:0] romData(input logic [11:0] a);
        if (a == 12'h041) return 12'h0F0;
        return a + 12'h123;
    endfunction

    // Synchronous ROM with one cycle read latency
    always @(posedge clk) begin
        rgb_pixel <= romData(pixel_addr);
    end

    // Tag pipeline marking which cycles carry a checked vector
    always @(posedge clk) begin
        tag1 <= tagIn;
        tag2 <= tag1;
        tag3 <= tag2;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: address one cycle after issue, composited output three cycles after
    always @(negedge clk) begin
        addrExp_t ae;
        outExp_t  oe;
        if (tag1) begin
            if (addrQ.size() == 0) begin
                checkOutput("addrQueueEmpty", 32'd1, 32'd0);
            end else begin
                ae = addrQ.pop_front();
                checkOutput("pixel_addr", 32'(pixel_addr), 32'(ae.addr));
                if (ae.rstChk) begin
                    checkOutput("rstRgbOut", 32'(rgb_out), 32'd0);
                    checkOutput("rstTiming",
                        32'({hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'd0);
                end
            end
        end
        if (tag3) begin
            if (outQ.size() == 0) begin
                checkOutput("outQueueEmpty", 32'd1, 32'd0);
            end else begin
                oe = outQ.pop_front();
                checkOutput("rgb_out", 32'(rgb_out), 32'(oe.rgb));
                checkOutput("hcount_out", 32'(hcount_out), 32'(oe.hcount));
                checkOutput("vcount_out", 32'(vcount_out), 32'(oe.vcount));
                checkOutput("syncBlank", 32'({hsync_out, hblnk_out, vsync_out, vblnk_out}), 32'(oe.syncs));
            end
        end
    end

    // Drive one pixel; tagged vectors also queue their hand-computed results
    task automatic applyStimulus(input logic r, input logic [10:0] h, input logic [10:0] v,
                                 input logic hb, input logic vb, input logic [11:0] bg,
                                 input logic tag, input logic [11:0] expAddr,
                                 input logic [11:0] expRgb);
        addrExp_t ae;
        outExp_t  oe;
        @(negedge clk);
        rst       = r;
        hcount_in = h;
        vcount_in = v;
        hsync_in  = h[3];
        vsync_in  = v[2];
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = bg;
        tagIn     = tag;
        if (tag) begin
            ae.addr   = expAddr;
            ae.rstChk = r;
            addrQ.push_back(ae);
            if (r) begin
                oe = '0;
            end else begin
                oe.hcount = h;
                oe.vcount = v;
                oe.syncs  = {h[3], hb, v[2], vb};
                oe.rgb    = expRgb;
            end
            outQ.push_back(oe);
        end
    endtask

    // Watchdog so the bench always ends
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed stimulus sequence
    initial begin
        // Reset held for two cycles
        applyStimulus(1, 11'd0, 11'd0, 0, 0, 12'hFFF, 1, 12'h000, 12'h000);
        applyStimulus(1, 11'd0, 11'd0, 0, 0, 12'hFFF, 1, 12'h000, 12'h000);

        // Vblank rise latches position (100,50)
        xpos = 12'd100;
        ypos = 12'd50;
        applyStimulus(0, 11'd0,   11'd0,  0, 1, 12'h111, 1, 12'h000, 12'h000);
        applyStimulus(0, 11'd100, 11'd50, 0, 0, 12'hABC, 1, 12'h000, 12'h123);
        applyStimulus(0, 11'd101, 11'd50, 0, 0, 12'hABC, 1, 12'h001, 12'h124);
        applyStimulus(0, 11'd99,  11'd50, 0, 0, 12'h3C5, 1, 12'h000, 12'h3C5);
        applyStimulus(0, 11'd163, 11'd113, 0, 0, 12'h888, 1, 12'hFFF, 12'h122);
        applyStimulus(0, 11'd164, 11'd113, 0, 0, 12'h777, 1, 12'h000, 12'h777);
        applyStimulus(0, 11'd100, 11'd114, 0, 0, 12'h456, 1, 12'h000, 12'h456);
        // Colour key shows background; blanking forces black
        applyStimulus(0, 11'd101, 11'd51, 0, 0, 12'h9A9, 1, 12'h041, 12'h9A9);
        applyStimulus(0, 11'd102, 11'd51, 0, 0, 12'h9A9, 1, 12'h042, 12'h165);
        applyStimulus(0, 11'd102, 11'd51, 1, 0, 12'h9A9, 1, 12'h000, 12'h000);
        applyStimulus(0, 11'd10,  11'd51, 1, 0, 12'h5A5, 1, 12'h000, 12'h000);

        // Mid-frame position change is deferred until the next vblank rise
        xpos = 12'd200;
        applyStimulus(0, 11'd100, 11'd50, 0, 0, 12'h222, 1, 12'h000, 12'h123);
        applyStimulus(0, 11'd200, 11'd50, 0, 0, 12'h333, 1, 12'h000, 12'h333);
        applyStimulus(0, 11'd0,   11'd0,  0, 1, 12'h444, 1, 12'h000, 12'h000);
        applyStimulus(0, 11'd200, 11'd50, 0, 0, 12'h555, 1, 12'h000, 12'h123);
        applyStimulus(0, 11'd263, 11'd50, 0, 0, 12'h555, 1, 12'h03F, 12'h162);
        applyStimulus(0, 11'd100, 11'd50, 0, 0, 12'h666, 1, 12'h000, 12'h666);

        // Position near 12-bit limit does not wrap to column 0
        xpos = 12'd4090;
        ypos = 12'd0;
        applyStimulus(0, 11'd0, 11'd0, 0, 1, 12'h000, 1, 12'h000, 12'h000);
        applyStimulus(0, 11'd5, 11'd0, 0, 0, 12'h2B2, 1, 12'h000, 12'h2B2);

        // Sprite clipped at the right edge of the counter range
        xpos = 12'd2000;
        applyStimulus(0, 11'd0,    11'd0, 0, 1, 12'h000, 1, 12'h000, 12'h000);
        applyStimulus(0, 11'd2047, 11'd0, 0, 0, 12'h0AA, 1, 12'h02F, 12'h152);

        // Reset mid-line with unchecked pixels in flight
        applyStimulus(0, 11'd2010, 11'd1, 0, 0, 12'hEEE, 0, 12'h000, 12'h000);
        applyStimulus(0, 11'd2011, 11'd1, 0, 0, 12'hEEE, 0, 12'h000, 12'h000);
        applyStimulus(1, 11'd2012, 11'd1, 0, 0, 12'hEEE, 1, 12'h000, 12'h000);
        // Position reverts to (0,0) after reset
        applyStimulus(0, 11'd10, 11'd5,  0, 0, 12'hC0C, 1, 12'h14A, 12'h26D);
        applyStimulus(0, 11'd70, 11'd5,  0, 0, 12'hC0C, 1, 12'h000, 12'hC0C);
        applyStimulus(0, 11'd63, 11'd63, 0, 0, 12'hC0C, 1, 12'hFFF, 12'h122);

        // Drain the pipeline
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 11'd0, 11'd200, 0, 0, 12'h000, 0, 12'h000, 12'h000);
        end
        @(negedge clk);
        checkOutput("addrQueueDrained", 32'(addrQ.size()), 32'd0);
        checkOutput("outQueueDrained", 32'(outQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
